// File: rtl/button_conditioner.sv
// Per-button synchroniser, debouncer and press/release edge detector for the front panel.
// Optional auto-repeat of press_o while a button stays held: define BTN_AUTOREPEAT_EN.
module button_conditioner #(
  parameter int unsigned NUM_BTNS        = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 20,
  parameter int unsigned REPEAT_PERIOD   = 5
) (
  input  logic                clk,
  input  logic                nRst_i,
  input  logic [NUM_BTNS-1:0] button_i,
  output logic [NUM_BTNS-1:0] level_o,
  output logic [NUM_BTNS-1:0] press_o,
  output logic [NUM_BTNS-1:0] release_o,
  output logic                any_press_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTNS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BTNS-1:0] synced;
  logic [CntW-1:0]     cnt_q  [NUM_BTNS];
  logic [CntW-1:0]     cnt_d  [NUM_BTNS];
  logic [NUM_BTNS-1:0] level_q, level_d;
  logic [NUM_BTNS-1:0] press_q, press_d;
  logic [NUM_BTNS-1:0] release_q, release_d;
  logic [NUM_BTNS-1:0] rise;

  assign synced = sync_q[SYNC_STAGES-1];

  // Level flips only after DEBOUNCE_CYCLES consecutive differing synced samples.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < int'(NUM_BTNS); i++) begin
      cnt_d[i] = '0;
      if (synced[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = synced[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise      = level_d & ~level_q;
  assign release_d = ~level_d & level_q;

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  logic [RptW-1:0]     rpt_cnt_q [NUM_BTNS];
  logic [RptW-1:0]     rpt_cnt_d [NUM_BTNS];
  logic [RptW-1:0]     rpt_next  [NUM_BTNS];
  logic [NUM_BTNS-1:0] rpt_phase_q, rpt_phase_d;
  logic [NUM_BTNS-1:0] rpt_hit;

  // rpt_phase_q selects between the initial delay and the steady repeat period.
  always_comb begin
    rpt_phase_d = rpt_phase_q;
    rpt_hit     = '0;
    for (int i = 0; i < int'(NUM_BTNS); i++) begin
      rpt_cnt_d[i] = rpt_cnt_q[i];
      rpt_next[i]  = rpt_cnt_q[i] + 1'b1;
      if (rise[i] || !level_d[i]) begin
        rpt_cnt_d[i]   = '0;
        rpt_phase_d[i] = 1'b0;
      end else if ((!rpt_phase_q[i] && rpt_next[i] == RptW'(REPEAT_DELAY)) ||
                   (rpt_phase_q[i] && rpt_next[i] == RptW'(REPEAT_PERIOD))) begin
        rpt_hit[i]     = 1'b1;
        rpt_cnt_d[i]   = '0;
        rpt_phase_d[i] = 1'b1;
      end else begin
        rpt_cnt_d[i] = rpt_next[i];
      end
    end
  end

  assign press_d = rise | rpt_hit;

  always_ff @(posedge clk) begin
    if (!nRst_i) begin
      rpt_phase_q <= '0;
      for (int i = 0; i < int'(NUM_BTNS); i++) rpt_cnt_q[i] <= '0;
    end else begin
      rpt_phase_q <= rpt_phase_d;
      for (int i = 0; i < int'(NUM_BTNS); i++) rpt_cnt_q[i] <= rpt_cnt_d[i];
    end
  end
`else
  assign press_d = rise;
`endif

  always_ff @(posedge clk) begin
    if (!nRst_i) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      for (int i = 0; i < int'(NUM_BTNS); i++) cnt_q[i] <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync_q[0] <= button_i;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      for (int i = 0; i < int'(NUM_BTNS); i++) cnt_q[i] <= cnt_d[i];
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o     = level_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign any_press_o = |press_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed panel scenarios plus random
// bouncing, compared every cycle against a run-length/age based reference model.
module tb_button_conditioner;

  localparam int unsigned NB = 4;
  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 5;

  logic          clk = 1'b0;
  logic          nrst;
  logic [NB-1:0] btn;
  logic [NB-1:0] level, press, rel;
  logic          anyp;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTNS       (NB),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .nRst_i     (nrst),
    .button_i   (btn),
    .level_o    (level),
    .press_o    (press),
    .release_o  (rel),
    .any_press_o(anyp)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: synced value is the raw input SS edges ago; level flips once DC
  // consecutive synced samples disagree; repeats follow from the age of the held press.
  logic [NB-1:0] pipe [SS];
  logic [NB-1:0] m_lvl, m_press, m_rel;
  int            run [NB];
  int            age [NB];
  int            p3_cnt;

  task automatic model_edge(input logic [NB-1:0] b, input logic r);
    logic [NB-1:0] s, prev;
    if (!r) begin
      for (int k = 0; k < int'(SS); k++) pipe[k] = '0;
      m_lvl = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < int'(NB); i++) begin run[i] = 0; age[i] = 0; end
    end else begin
      s = pipe[SS-1];
      for (int k = int'(SS) - 1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = b;
      prev = m_lvl;
      for (int i = 0; i < int'(NB); i++) begin
        if (s[i] != m_lvl[i]) begin
          run[i]++;
          if (run[i] == int'(DC)) begin
            m_lvl[i] = s[i];
            run[i]   = 0;
          end
        end else begin
          run[i] = 0;
        end
        m_press[i] = 1'b0;
        m_rel[i]   = prev[i] & ~m_lvl[i];
        if (m_lvl[i] && !prev[i]) begin
          age[i]     = 0;
          m_press[i] = 1'b1;
        end else if (m_lvl[i]) begin
          age[i]++;
`ifdef BTN_AUTOREPEAT_EN
          m_press[i] = (age[i] >= int'(RD)) && ((age[i] - int'(RD)) % int'(RP) == 0);
`endif
        end
      end
    end
  endtask

  task automatic check(input string tag);
    n_cmp++;
    assert (level === m_lvl) else begin
      n_fail++; $error("FAIL %s level_o: observed %h expected %h", tag, level, m_lvl);
    end
    n_cmp++;
    assert (press === m_press) else begin
      n_fail++; $error("FAIL %s press_o: observed %h expected %h", tag, press, m_press);
    end
    n_cmp++;
    assert (rel === m_rel) else begin
      n_fail++; $error("FAIL %s release_o: observed %h expected %h", tag, rel, m_rel);
    end
    n_cmp++;
    assert (anyp === (|m_press)) else begin
      n_fail++; $error("FAIL %s any_press_o: observed %b expected %b", tag, anyp, |m_press);
    end
    n_cmp++;
    assert ((press & rel) === '0) else begin
      n_fail++; $error("FAIL %s press&release: observed %h expected 0", tag, press & rel);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare on the falling edge.
  task automatic step(input logic [NB-1:0] b, input logic r, input string tag);
    btn  = b;
    nrst = r;
    @(posedge clk);
    model_edge(b, r);
    @(negedge clk);
    if (press[3]) p3_cnt++;
    check(tag);
  endtask

  initial begin
    logic [NB-1:0] rb;
    int            exp_p3;
    p3_cnt = 0;
    btn    = '0;
    nrst   = 1'b0;
    @(negedge clk);

    for (int c = 0; c < 3; c++) step(4'hF, 1'b0, "reset_hold");
    n_cmp++;
    assert ({level, press, rel, anyp} === '0) else begin
      n_fail++; $error("FAIL reset_outputs: observed %h expected 0", {level, press, rel, anyp});
    end

    for (int c = 0; c < 5; c++) step(4'hF, 1'b1, "reset_release");
    step(4'hF, 1'b1, "reset_release");
    n_cmp++;
    assert (press === 4'hF) else begin
      n_fail++; $error("FAIL reset_press_latency: observed %h expected f", press);
    end
    for (int c = 0; c < 4; c++) step(4'hF, 1'b1, "held_after_reset");
    step(4'h0, 1'b0, "reset_mid_press");
    for (int c = 0; c < 12; c++) step(4'h0, 1'b1, "idle");

    for (int c = 0; c < 20; c++) step(4'h1, 1'b1, "clean_press");
    for (int c = 0; c < 10; c++) step(4'h0, 1'b1, "release");

    step(4'h2, 1'b1, "bounce");
    step(4'h0, 1'b1, "bounce");
    step(4'h2, 1'b1, "bounce");
    step(4'h0, 1'b1, "bounce");
    for (int c = 0; c < 12; c++) step(4'h2, 1'b1, "bounce_hold");
    for (int c = 0; c < 10; c++) step(4'h0, 1'b1, "bounce_release");

    for (int c = 0; c < 3; c++) step(4'h4, 1'b1, "glitch");
    for (int c = 0; c < 10; c++) step(4'h0, 1'b1, "glitch_after");

    p3_cnt = 0;
    for (int c = 0; c < 40; c++) step(4'h8, 1'b1, "repeat_hold");
    for (int c = 0; c < 10; c++) step(4'h0, 1'b1, "repeat_release");
`ifdef BTN_AUTOREPEAT_EN
    exp_p3 = 5;
`else
    exp_p3 = 1;
`endif
    n_cmp++;
    assert (p3_cnt == exp_p3) else begin
      n_fail++; $error("FAIL repeat_count: observed %0d expected %0d", p3_cnt, exp_p3);
    end

    rb = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(NB); i++) begin
        if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
      end
      step(rb, ($urandom_range(0, 150) != 0), "random");
    end
    for (int c = 0; c < 10; c++) step(4'h0, 1'b1, "drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
